// File: rtl/immediate_prefetcher.sv
// Sequential instruction-word prefetcher: a request/ack memory port fills a DEPTH-entry FIFO,
// and the head word is presented decoded as an immediate/offset pair.
module immediate_prefetcher #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int SHORT_BITS  = 11,
    parameter int OFFSET_BITS = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_flush_pc,
    output logic                     o_mem_read_req,
    output logic [WIDTH-1:0]         o_mem_read_address,
    input  logic                     i_mem_read_ack,
    input  logic                     i_mem_read_valid,
    input  logic [WIDTH-1:0]         i_mem_data_in,
    input  logic                     i_consume,
    input  logic                     i_destination_mem,
    output logic                     o_out_valid,
    output logic [WIDTH-1:0]         o_out_pc,
    output logic [WIDTH-1:0]         o_immediate,
    output logic [OFFSET_BITS-1:0]   o_offset,
    output logic                     o_can_halt,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int EXT = WIDTH - SHORT_BITS;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rptr;
    logic [AW-1:0]    r_wptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] r_head_pc;
    logic             r_inflight;

    logic [CW:0]      w_credit;
    logic             w_req;
    logic             w_ack;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    // An outstanding request already owns a FIFO slot, so a response can never overflow.
    assign w_credit = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_req    = i_reset_n && !i_flush && (w_credit < (CW+1)'(DEPTH));
    assign w_ack    = w_req && i_mem_read_ack;
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    // Responses without a matching request, or landing in a flush cycle, are dropped.
    assign w_push   = i_reset_n && !i_flush && i_mem_read_valid && r_inflight && !w_full;
    assign w_pop    = i_reset_n && !i_flush && i_consume && !w_empty;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_fetch_pc <= '0;
            r_head_pc  <= '0;
            r_inflight <= 1'b0;
        end else if (i_flush) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_fetch_pc <= i_flush_pc;
            r_head_pc  <= i_flush_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_ack;
            if (w_ack)
                r_fetch_pc <= r_fetch_pc + WIDTH'(1);
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop) begin
                r_rptr    <= r_rptr + AW'(1);
                r_head_pc <= r_head_pc + WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; stale contents are masked by out_valid.
    always_ff @(posedge i_clock) begin
        if (w_push)
            r_mem[r_wptr] <= i_mem_data_in;
    end

    assign w_head = r_mem[r_rptr];

    always_comb begin
        o_immediate = '0;
        o_offset    = '0;
        if (!w_empty) begin
            if (i_destination_mem) begin
                o_immediate = {{EXT{w_head[SHORT_BITS-1]}}, w_head[SHORT_BITS-1:0]};
                o_offset    = w_head[WIDTH-1 -: OFFSET_BITS];
            end else begin
                o_immediate = w_head;
            end
        end
    end

    assign o_mem_read_req     = w_req;
    assign o_mem_read_address = r_fetch_pc;
    assign o_out_valid        = !w_empty;
    assign o_out_pc           = r_head_pc;
    assign o_can_halt         = !w_empty && (w_head == '0);
    assign o_count            = r_count;

endmodule
